// File: rtl/ram_banked_sync.sv
// Banked synchronous scratch RAM: independent single-port banks, 1-cycle registered reads,
// sticky out-of-range flags, and a zero-fill sweep after reset or clear_req (ready low meanwhile).
module ram_banked_sync #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 2500
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear_req,
    output logic                             ready,
    input  logic [NUM_BANKS-1:0]             req_valid,
    input  logic [NUM_BANKS-1:0]             req_write,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_BANKS-1:0]             rd_valid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_BANKS-1:0]             oob_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH-1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  run_clear;

    assign ready     = (state == ST_RUN);
    assign run_clear = ready & clear_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (init_cnt == LAST) begin
                state    <= ST_RUN;
                init_cnt <= '0;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end else if (clear_req) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] addr;
        logic [IDX_W-1:0]      idx;
        logic                  in_range;
        logic                  acc;
        logic                  vld_q;
        logic                  oob_q;
        logic [DATA_WIDTH-1:0] dat_q;

        assign addr     = req_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
        assign idx      = addr[IDX_W-1:0];
        assign in_range = ({1'b0, addr} < DEPTH_L);
        assign acc      = ready & req_valid[b];

        // Storage has no reset; the sweep owns the write port while ready is low.
        always_ff @(posedge clk) begin
            if (!ready) begin
                mem[init_cnt[IDX_W-1:0]] <= '0;
            end else if (acc && req_write[b] && in_range) begin
                mem[idx] <= req_wdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
                oob_q <= 1'b0;
            end else begin
                vld_q <= acc & ~req_write[b];
                if (acc && !req_write[b]) begin
                    dat_q <= in_range ? mem[idx] : '0;
                end
                if (run_clear) begin
                    oob_q <= 1'b0;
                end else if (acc && !in_range) begin
                    oob_q <= 1'b1;
                end
            end
        end

        assign rd_valid[b]                          = vld_q;
        assign rd_data[b*DATA_WIDTH +: DATA_WIDTH]  = dat_q;
        assign oob_err[b]                           = oob_q;
    end
endmodule

// File: tb/tb_ram_banked_sync.sv
// Scoreboarded bench for ram_banked_sync with a small DEPTH so sweeps stay short.
module tb_ram_banked_sync;
    localparam int DW    = 64;
    localparam int NB    = 4;
    localparam int AW    = 12;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear_req;
    logic               ready;
    logic [NB-1:0]      req_valid;
    logic [NB-1:0]      req_write;
    logic [NB*AW-1:0]   req_addr;
    logic [NB*DW-1:0]   req_wdata;
    logic [NB-1:0]      rd_valid;
    logic [NB*DW-1:0]   rd_data;
    logic [NB-1:0]      oob_err;

    typedef struct packed {
        logic [1:0]    bank;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ram_banked_sync #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .rd_valid(rd_valid), .rd_data(rd_data), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every rd_valid strobe must match the oldest outstanding expected read.
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (rd_valid[b] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd_valid bank %0d: got data %h expected no response",
                             b, rd_data[b*DW +: DW]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.bank != 2'(b) || rd_data[b*DW +: DW] !== e.data) begin
                        errors++;
                        $display("FAIL rd_data: got bank %0d data %h expected bank %0d data %h",
                                 b, rd_data[b*DW +: DW], e.bank, e.data);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        req_valid = '0;
        req_write = '0;
        clear_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wr(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[b]         = 1'b1;
        req_write[b]         = 1'b1;
        req_addr[b*AW +: AW] = a;
        req_wdata[b*DW +: DW] = d;
    endtask

    task automatic rd(input int b, input logic [AW-1:0] a, input logic [DW-1:0] e, input bit expect_rsp);
        exp_t x;
        req_valid[b]         = 1'b1;
        req_write[b]         = 1'b0;
        req_addr[b*AW +: AW] = a;
        if (expect_rsp) begin
            x.bank = 2'(b);
            x.data = e;
            exp_q.push_back(x);
        end
    endtask

    // Counts edges until ready; optionally pulses clear_req mid-sweep (must be ignored).
    task automatic wait_ready(input int clr_at, output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            idle_inputs();
            n++;
            if (n == clr_at) clear_req = 1'b1;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready after %0d cycles expected ready", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd0);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_oob_err"}, 64'(oob_err), 64'd0);
        for (int b = 0; b < NB; b++) check($sformatf("%s_rd_data_b%0d", tag, b), rd_data[b*DW +: DW], 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        req_addr = '0;
        req_wdata = '0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Initial sweep length
        wait_ready(0, n);
        check("init_sweep_cycles", 64'(n), 64'(DEPTH));

        // Every address of every bank reads back zero
        for (int a = 0; a < DEPTH; a++) begin
            for (int b = 0; b < NB; b++) rd(b, AW'(a), 64'd0, 1'b1);
            step();
        end
        step();

        // Write then read, bank 2 only
        wr(2, 12'd7, 64'hDEAD_BEEF_0123_4567);
        step();
        check("write_no_rd_valid", 64'(rd_valid), 64'd0);
        rd(2, 12'd7, 64'hDEAD_BEEF_0123_4567, 1'b1);
        step();
        check("wr_rd_valid_mask", 64'(rd_valid), 64'h4);
        step();

        // Parallel write/read on all banks
        for (int b = 0; b < NB; b++) wr(b, 12'd5, 64'(b) * 64'h1111);
        step();
        for (int b = 0; b < NB; b++) rd(b, 12'd5, 64'(b) * 64'h1111, 1'b1);
        step();
        check("parallel_rd_valid_mask", 64'(rd_valid), 64'hF);

        // Back-to-back reads keep rd_valid high
        rd(3, 12'd5, 64'h3333, 1'b1);
        step();
        rd(3, 12'd7, 64'd0, 1'b1);
        step();
        check("b2b_rd_valid_1", 64'(rd_valid[3]), 64'd1);
        step();
        check("b2b_rd_valid_2", 64'(rd_valid), 64'd0);

        // Out of range on bank 1
        wr(1, 12'd3000, 64'hABCD);
        step();
        check("oob_after_write", 64'(oob_err), 64'h2);
        rd(1, 12'd3000, 64'd0, 1'b1);
        step();
        rd(1, 12'd8, 64'd0, 1'b1);  // 3000 mod 16: aliased slot must be untouched
        step();
        rd(1, 12'd5, 64'h1111, 1'b1);
        step();
        step();
        check("oob_sticky", 64'(oob_err), 64'h2);
        check("rd_data_hold_b2", rd_data[2*DW +: DW], 64'h2222);

        // clear_req re-runs the sweep
        wr(0, 12'd3, 64'h5);
        step();
        clear_req = 1'b1;
        step();
        check("clear_ready_low", 64'(ready), 64'd0);
        check("clear_oob_cleared", 64'(oob_err), 64'd0);
        rd(0, 12'd3, 64'd0, 1'b0);
        wait_ready(5, n);
        check("clear_sweep_cycles", 64'(n), 64'(DEPTH));
        rd(0, 12'd3, 64'd0, 1'b1);
        step();
        step();
        check("rd_data_hold_after_clear", rd_data[2*DW +: DW], 64'h2222);

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        step();
        repeat (8) step();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midsweep_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(0, n);
        check("reset_sweep_cycles", 64'(n), 64'(DEPTH));
        rd(1, 12'd5, 64'd0, 1'b1);
        rd(2, 12'd7, 64'd0, 1'b1);
        step();
        step();
        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_banked_sync.md
Name: ram_banked_sync

Overview:
- Parametrised multi-bank scratch memory for the ODE solver datapath. It replaces fixed four-bank asynchronous-read storage for the U, A, B and X/H/N/T operand tables.
- NUM_BANKS independent single-port banks, each of uniform DEPTH.
- Registered reads with a valid strobe; out-of-range detection.
- Hardware zero-initialisation sweep after reset or on request, so the solver never reads stale operands.

Parameters:
- DATA_WIDTH, 64, word width of every bank.
- NUM_BANKS, 4, number of independent banks.
- ADDR_WIDTH, 12, per-bank address width.
- DEPTH, 2500, words per bank; must satisfy DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear_req  input  1  one-cycle pulse; re-runs the zero-init sweep.
- ready  output  1  high when banks accept requests.
- req_valid  input  NUM_BANKS  per-bank request strobe.
- req_write  input  NUM_BANKS  per-bank request type: 1 = write, 0 = read.
- req_addr  input  NUM_BANKS*ADDR_WIDTH  per-bank address; bank b occupies bits [b*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_BANKS*DATA_WIDTH  per-bank write data; bank b occupies bits [b*DATA_WIDTH +: DATA_WIDTH].
- rd_valid  output  NUM_BANKS  per-bank read-data-valid strobe.
- rd_data  output  NUM_BANKS*DATA_WIDTH  per-bank registered read data.
- oob_err  output  NUM_BANKS  sticky per-bank out-of-range flag.

Behaviour:
- Reset (async, rst=1): state=INIT, init_cnt=0, ready=0, rd_valid=0, rd_data=0, oob_err=0. Memory contents are not reset directly; the sweep clears them.
- FSM has two states, INIT and RUN.
  - INIT: each cycle writes 0 to address init_cnt in every bank, then increments init_cnt. When init_cnt==DEPTH-1 that write completes and the next state is RUN. Sweep length is exactly DEPTH cycles after rst deasserts.
  - RUN: ready=1. A clear_req=1 sampled in RUN goes to INIT with init_cnt=0, ready=0 the next cycle, and oob_err cleared.
  - clear_req in INIT is ignored; the sweep is not restarted.
- Reset asserted mid-sweep restarts the sweep from address 0 after deassertion.
- While ready=0, all req_valid are ignored: no writes, rd_valid stays 0, oob_err is not updated.
- Banks are fully independent. Simultaneous requests on all banks complete in the same cycle, and there is no cross-bank arbitration.
- Write, in RUN with req_valid[b]=1, req_write[b]=1 and addr<DEPTH: mem_b[addr] <= wdata at the edge. rd_valid[b]=0 the next cycle.
- Read, in RUN with req_valid[b]=1, req_write[b]=0 and addr<DEPTH: at the next edge rd_data[b] <= mem_b[addr] and rd_valid[b]=1. Latency is exactly 1 cycle.
  - Back-to-back reads on consecutive cycles give rd_valid high continuously.
  - A read one cycle after a write to the same address returns the new data.
- Out of range (addr >= DEPTH, possible when DEPTH < 2**ADDR_WIDTH):
  - A write is dropped and memory is unchanged.
  - A read returns rd_data[b]=0 with rd_valid[b]=1.
  - In both cases oob_err[b] sets and stays set until rst or clear_req.
- rd_data[b] holds its last value when rd_valid[b]=0. Only rst clears it.
- Memory contents are preserved across RUN cycles with no request.

Test Plan:
- Init sweep: DEPTH=16; deassert rst. ready rises exactly 16 cycles later. A read of every address in every bank returns 0.
- Write then read: bank 2 writes 64'hDEAD_BEEF_0123_4567 to address 7; next cycle bank 2 reads address 7. One cycle later rd_valid[2]=1 and rd_data[2]=64'hDEAD_BEEF_0123_4567. Other banks show rd_valid=0.
- Parallel banks: all 4 banks write distinct values (bank index * 64'h1111) to address 5 in the same cycle, then all read it. Each bank returns its own value in the same cycle.
- Out of range: DEPTH=2500, ADDR_WIDTH=12; bank 1 writes to address 3000, then reads 3000.
  - oob_err[1]=1 and rd_data[1]=0 with rd_valid[1]=1.
  - Address 3000 mod 2500 = 500 is still unchanged.
  - oob_err of the other banks stays 0.
- clear_req: fill bank 0 address 3 with 64'h5; pulse clear_req.
  - ready=0 for DEPTH cycles and oob_err clears.
  - A read request issued during the sweep gives no rd_valid.
  - After ready=1, a read of address 3 returns 0.
- Reset mid-sweep: assert rst at sweep count 8 (DEPTH=16) and deassert. ready rises exactly 16 cycles after the deassertion, and all outputs are 0 during reset.
